// File: rtl/neuron_mac_sequencer.sv
// rtl/neuron_mac_sequencer.sv - reads (x,w) byte pairs from RAM, accumulates x*w, writes back a shifted/ReLU/saturated activation
module neuron_mac_sequencer #(
  parameter int N_INPUTS    = 2,
  parameter int BASE_ADDR   = 0,
  parameter int RESULT_ADDR = 4,
  parameter int SHIFT       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic [7:0] read_address,
  output logic       oe,
  input  logic [7:0] read_data,
  output logic [7:0] write_address,
  output logic [7:0] write_data,
  output logic       wre,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int ACC_RAW = 16 + $clog2(N_INPUTS);
  localparam int ACC_W   = (ACC_RAW < 17) ? 17 : ACC_RAW;
  localparam int K_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_INPUTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_X,
    S_FETCH_W,
    S_ACT,
    S_OUT
  } state_t;

  state_t                   state, state_next;
  logic [K_W-1:0]           k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [7:0]        x_reg;
  logic [7:0]               out_q;

  logic [7:0]               pair_addr;
  logic signed [15:0]       prod;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;
  logic [7:0]               act_val;

  // x of pair k sits at BASE_ADDR+2k, w right after it; sums wrap at 8 bits
  assign pair_addr = 8'(BASE_ADDR) + 8'({k, 1'b0});
  assign prod      = x_reg * $signed(read_data);
  assign acc_next  = acc + {{(ACC_W-16){prod[15]}}, prod};

  // Sign bit gives ReLU; any set bit from 7 upward (when non-negative) means >127
  assign shifted = acc >>> SHIFT;
  always_comb begin
    act_val = shifted[7:0];
    if (shifted[ACC_W-1])
      act_val = 8'd0;
    else if (|shifted[ACC_W-2:7])
      act_val = 8'd127;
  end

  always_comb begin
    state_next    = state;
    busy          = (state != S_IDLE);
    oe            = 1'b0;
    read_address  = 8'd0;
    wre           = 1'b0;
    write_address = 8'd0;
    write_data    = 8'd0;
    out_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)
          state_next = S_FETCH_X;
      end
      S_FETCH_X: begin
        oe           = 1'b1;
        read_address = pair_addr;
        state_next   = S_FETCH_W;
      end
      S_FETCH_W: begin
        oe           = 1'b1;
        read_address = pair_addr + 8'd1;
        state_next   = (k == K_LAST) ? S_ACT : S_FETCH_X;
      end
      S_ACT: begin
        wre           = 1'b1;
        write_address = 8'(RESULT_ADDR);
        write_data    = act_val;
        state_next    = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      acc   <= '0;
      x_reg <= '0;
      out_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc <= '0;
            k   <= '0;
          end
        end
        S_FETCH_X: x_reg <= $signed(read_data);
        S_FETCH_W: begin
          acc <= acc_next;
          if (k != K_LAST)
            k <= k + 1'b1;
        end
        S_ACT: out_q <= act_val;
        default: ;
      endcase
    end
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb/tb_neuron_mac_sequencer.sv - bench for neuron_mac_sequencer across several parameter sets sharing one RAM
module tb_neuron_mac_sequencer;

  localparam int NI = 6;

  function automatic int p_n(input int g);
    case (g)
      4:       p_n = 7;
      5:       p_n = 1;
      default: p_n = 2;
    endcase
  endfunction

  function automatic int p_base(input int g);
    case (g)
      3:       p_base = 254;
      4:       p_base = 16;
      default: p_base = 0;
    endcase
  endfunction

  function automatic int p_res(input int g);
    case (g)
      4:       p_res = 200;
      5:       p_res = 9;
      default: p_res = 4;
    endcase
  endfunction

  function automatic int p_shift(input int g);
    case (g)
      1:       p_shift = 1;
      2:       p_shift = 2;
      4:       p_shift = 5;
      5:       p_shift = 7;
      default: p_shift = 0;
    endcase
  endfunction

  logic            clk;
  logic            rst;
  logic [NI-1:0]   start;
  logic [NI-1:0]   out_ready;
  logic            chk_en;
  logic [7:0]      ram [256];

  logic            busy_w [NI];
  logic            oe_w   [NI];
  logic            wre_w  [NI];
  logic            ov_w   [NI];
  logic [7:0]      ra     [NI];
  logic [7:0]      rd     [NI];
  logic [7:0]      wa     [NI];
  logic [7:0]      wd     [NI];
  logic [7:0]      od     [NI];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst%0d got %0d expected %0d at %0t", name, g, got, exp, $time);
    end
  endtask

  // Reference neuron: plain signed dot product over the pair layout, then shift/ReLU/clip
  function automatic logic [7:0] model_act(input int base, input int n, input int sh);
    longint acc;
    longint s;
    acc = 0;
    for (int i = 0; i < n; i++)
      acc += longint'($signed(ram[(base + 2*i) % 256])) * longint'($signed(ram[(base + 2*i + 1) % 256]));
    s = acc >>> sh;
    if (s < 0) return 8'd0;
    if (s > 127) return 8'd127;
    return s[7:0];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int N  = p_n(g);
    localparam int B  = p_base(g);
    localparam int R  = p_res(g);
    localparam int SH = p_shift(g);

    bit         m_busy;
    int         m_c;
    logic [7:0] m_res;
    logic [7:0] m_out;
    int         m_results;
    bit         e_fetch, e_act, e_out;

    assign rd[g] = ram[ra[g]];

    neuron_mac_sequencer #(
      .N_INPUTS(N), .BASE_ADDR(B), .RESULT_ADDR(R), .SHIFT(SH)
    ) dut (
      .clk(clk), .rst(rst), .start(start[g]), .busy(busy_w[g]),
      .read_address(ra[g]), .oe(oe_w[g]), .read_data(rd[g]),
      .write_address(wa[g]), .write_data(wd[g]), .wre(wre_w[g]),
      .out_data(od[g]), .out_valid(ov_w[g]), .out_ready(out_ready[g])
    );

    // m_c counts cycles since start was taken: 2N fetch cycles, one write cycle, then output
    initial m_results = 0;
    always @(posedge clk) begin
      if (rst) begin
        m_busy = 1'b0;
        m_c    = 0;
        m_out  = 8'd0;
        m_res  = 8'd0;
      end else if (!m_busy) begin
        if (start[g]) begin
          m_busy = 1'b1;
          m_c    = 0;
          m_res  = model_act(B, N, SH);
        end
      end else if (m_c == 2*N + 1) begin
        if (out_ready[g]) begin
          m_busy = 1'b0;
          m_results++;
        end
      end else begin
        if (m_c == 2*N) m_out = m_res;
        m_c++;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        e_fetch = m_busy && (m_c < 2*N);
        e_act   = m_busy && (m_c == 2*N);
        e_out   = m_busy && (m_c == 2*N + 1);
        check("busy", g, busy_w[g], m_busy);
        check("oe", g, oe_w[g], e_fetch);
        check("read_address", g, ra[g], e_fetch ? (B + m_c) % 256 : 0);
        check("wre", g, wre_w[g], e_act);
        check("write_address", g, wa[g], e_act ? R : 0);
        check("write_data", g, wd[g], e_act ? m_res : 8'd0);
        check("out_valid", g, ov_w[g], e_out);
        check("out_data", g, od[g], m_out);
      end
    end
  end

  task automatic load_t1();
    ram[0] = 8'd10; ram[1] = 8'd10; ram[2] = 8'd11; ram[3] = 8'd11;
  endtask

  // Pulse start on the chosen instances; returns at the first negedge after the start edge
  task automatic launch(input logic [NI-1:0] m);
    start = m;
    @(negedge clk);
    start = '0;
  endtask

  initial begin
    int r0;
    logic [7:0] t6a [4];
    t6a = '{8'd254, 8'd255, 8'd0, 8'd1};
    rst = 1'b1; start = '0; out_ready = '1; chk_en = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 0, busy_w[0], 0);
    check("reset_out_data", 0, od[0], 0);
    check("reset_out_valid", 0, ov_w[0], 0);
    rst = 1'b0;

    // T1 / T2 / T6 together
    load_t1();
    ram[254] = 8'd3; ram[255] = 8'd4;
    @(negedge clk);
    launch(6'b001111);
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        check("t6_read_address", 3, ra[3], t6a[c]);
        check("t6_oe_fetch", 3, oe_w[3], 1);
      end else begin
        check("t6_oe_low", 3, oe_w[3], 0);
      end
      if (c < 5) check("t1_out_valid_early", 0, ov_w[0], 0);
      if (c == 4) begin
        check("t1_wre", 0, wre_w[0], 1);
        check("t1_write_address", 0, wa[0], 4);
        check("t1_write_data", 0, wd[0], 127);
      end
      if (c == 5) begin
        check("t1_out_valid", 0, ov_w[0], 1);
        check("t1_out_data", 0, od[0], 127);
        check("t2_shift1", 1, od[1], 110);
        check("t2_shift2", 2, od[2], 55);
        check("t6_out_data", 3, od[3], 112);
      end
      @(negedge clk);
    end
    check("t1_idle_after", 0, busy_w[0], 0);
    check("t6_oe_idle", 3, oe_w[3], 0);

    // T3 ReLU
    ram[0] = 8'hFD; ram[1] = 8'd5; ram[2] = 8'd2; ram[3] = 8'd3;
    launch(6'b000001);
    repeat (4) @(negedge clk);
    check("t3_wre", 0, wre_w[0], 1);
    check("t3_write_address", 0, wa[0], 4);
    check("t3_write_data", 0, wd[0], 0);
    @(negedge clk);
    check("t3_out_valid", 0, ov_w[0], 1);
    check("t3_out_data", 0, od[0], 0);
    @(negedge clk);

    // T4 backpressure
    load_t1();
    out_ready[0] = 1'b0;
    launch(6'b000001);
    repeat (5) @(negedge clk);
    r0 = g_inst[0].m_results;
    for (int i = 0; i < 6; i++) begin
      check("t4_out_valid_hold", 0, ov_w[0], 1);
      check("t4_out_data_hold", 0, od[0], 127);
      start[0] = (i == 2);
      @(negedge clk);
    end
    start[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("t4_idle_after_ready", 0, busy_w[0], 0);
    check("t4_out_valid_drop", 0, ov_w[0], 0);
    repeat (2) @(negedge clk);
    check("t4_start_ignored", 0, busy_w[0], 0);
    check("t4_one_result", 0, g_inst[0].m_results - r0, 1);

    // T5 reset during FETCH_W of pair 0
    launch(6'b000001);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", 0, busy_w[0], 0);
    check("t5_oe", 0, oe_w[0], 0);
    check("t5_read_address", 0, ra[0], 0);
    check("t5_wre", 0, wre_w[0], 0);
    check("t5_out_valid", 0, ov_w[0], 0);
    check("t5_out_data", 0, od[0], 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_wre", 0, wre_w[0], 0);
      check("t5_no_out_valid", 0, ov_w[0], 0);
    end
    launch(6'b000001);
    repeat (5) @(negedge clk);
    check("t5_rerun_out_valid", 0, ov_w[0], 1);
    check("t5_rerun_out_data", 0, od[0], 127);
    repeat (2) @(negedge clk);

    // Randomized traffic, RAM only changes while every instance is drained
    for (int b = 0; b < 12; b++) begin
      for (int i = 0; i < 256; i++) begin
        if (b == 0)      ram[i] = 8'h80;
        else if (b == 1) ram[i] = i[0] ? 8'h7F : 8'h80;
        else             ram[i] = 8'($urandom);
      end
      for (int i = 0; i < 150; i++) begin
        start     = NI'($urandom) & NI'($urandom);
        out_ready = NI'($urandom) | NI'($urandom);
        rst       = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
      start = '0; out_ready = '1; rst = 1'b0;
      repeat (40) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
